riscv_core_mul_unit: RTL and testbench

Pipelined RV64 M-extension multiply unit: takes raw operands plus an op select, forms operand magnitudes, multiplies, applies sign correction and selects the result. It covers MUL/MULH/MULHSU/MULHU/MULW. It sits in the execute stage next to the ALU, behind a valid/ready handshake. It adds configurable latency, back-pressure, flush and a destination tag travelling with each operation.

---
 rtl/riscv_core_mul_pkg.sv | 35 +++
 rtl/riscv_core_mul_unit_if.sv | 34 +++
 rtl/riscv_core_mul_skid.sv | 42 ++++
 rtl/riscv_core_mul_unit.sv | 195 +++++++++++++++++++
 tb/tb_riscv_core_mul_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_mul_pkg.sv
// riscv_core_mul_pkg
// Shared types and constants for the RV64 M-extension multiply unit.
//   mul_op_e       : operation select encoding on i_mul_control
//   mul_ctrl_t     : width-independent part of the per-stage payload
//   MUL_MIN_STAGES : smallest supported pipeline depth
//   mul_a_signed / mul_b_signed : effective operand signedness per op
package riscv_core_mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    localparam int unsigned MUL_MIN_STAGES = 2;

    // Operand magnitudes and the tag depend on module parameters, so the
    // full stage payload is built in the unit around this control part.
    typedef struct packed {
        mul_op_e op;
        logic    isword;
        logic    neg;
    } mul_ctrl_t;

    // Word ops always treat both (truncated) operands as signed.
    function automatic logic mul_a_signed(input mul_op_e op, input logic isword);
        return isword || (op != MUL_OP_MULHU);
    endfunction

    function automatic logic mul_b_signed(input mul_op_e op, input logic isword);
        return isword || (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/riscv_core_mul_unit_if.sv
// riscv_core_mul_unit_if
// Issue/result handshake bundle between the execute stage and the multiply
// unit. Signal names match the unit's original port names.
//   master : execute-stage side (offers ops, consumes results, drives flush)
//   slave  : multiply unit side
interface riscv_core_mul_unit_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
);
    logic             i_mul_valid;
    logic             o_mul_ready;
    logic [XLEN-1:0]  i_mul_srcA;
    logic [XLEN-1:0]  i_mul_srcB;
    logic [1:0]       i_mul_control;
    logic             i_mul_isword;
    logic [TAG_W-1:0] i_mul_tag;
    logic             i_mul_flush;
    logic             o_mul_valid;
    logic             i_mul_ready;
    logic [XLEN-1:0]  o_mul_result;
    logic [TAG_W-1:0] o_mul_tag;

    modport master (
        output i_mul_valid, i_mul_srcA, i_mul_srcB, i_mul_control,
               i_mul_isword, i_mul_tag, i_mul_flush, i_mul_ready,
        input  o_mul_ready, o_mul_valid, o_mul_result, o_mul_tag
    );

    modport slave (
        input  i_mul_valid, i_mul_srcA, i_mul_srcB, i_mul_control,
               i_mul_isword, i_mul_tag, i_mul_flush, i_mul_ready,
        output o_mul_ready, o_mul_valid, o_mul_result, o_mul_tag
    );
endinterface

// File: rtl/riscv_core_mul_skid.sv
// riscv_core_mul_skid
// Generic 1-entry valid/ready skid buffer. Empty: pass-through with no added
// latency. Full: presents the buffered word and deasserts up_ready, which is
// a plain register output (no combinational path from dn_ready).
//   clk, rst, flush      : clock, sync active-high reset, drop buffered entry
//   up_valid/ready/data  : upstream side
//   dn_valid/ready/data  : downstream side
module riscv_core_mul_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);
    logic         full;
    logic [W-1:0] buf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            buf_q <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (full) begin
            if (dn_ready) full <= 1'b0;
        end else if (up_valid && !dn_ready) begin
            full  <= 1'b1;
            buf_q <= up_data;
        end
    end

    assign up_ready = !full;
    assign dn_valid = full || up_valid;
    assign dn_data  = full ? buf_q : up_data;

endmodule

// File: rtl/riscv_core_mul_unit.sv
// riscv_core_mul_unit
// Pipelined RV64 M-extension multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Stage 1 registers operand magnitudes and the result sign, stages
// 2..STAGES-1 form the unsigned product, the final stage sign-corrects and
// selects the result. Results leave in acceptance order, tag alongside.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   mul    : riscv_core_mul_unit_if.slave (issue, result, flush handshake)
// Parameters: XLEN (even, >= 8), STAGES (>= MUL_MIN_STAGES), TAG_W.
// Build option RISCV_CORE_MUL_SKID_EN: adds a 1-entry output skid buffer so
// o_mul_ready is registered; otherwise o_mul_ready = !(valid & !ready).
module riscv_core_mul_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input logic                  i_clk,
    input logic                  i_rst,
    riscv_core_mul_unit_if.slave mul
);
    import riscv_core_mul_pkg::*;

    localparam int unsigned HALF   = XLEN / 2;
    localparam int unsigned PDEPTH = STAGES - MUL_MIN_STAGES;

    typedef struct packed {
        logic [XLEN-1:0]  mag_a;
        logic [XLEN-1:0]  mag_b;
        mul_ctrl_t        ctrl;
        logic [TAG_W-1:0] tag;
    } mul_stage_t;

    logic adv;
    logic accept;

    // ---------------- stage 1: signs and magnitudes ----------------
    mul_op_e         op_in;
    logic [XLEN-1:0] a_ext, b_ext;
    logic            sa, sb;
    mul_stage_t      s1_d, s1_q;
    logic            s1_valid;

    assign op_in  = mul_op_e'(mul.i_mul_control);
    assign accept = mul.i_mul_valid && adv && !mul.i_mul_flush;

    always_comb begin
        a_ext = mul.i_mul_srcA;
        b_ext = mul.i_mul_srcB;
        if (mul.i_mul_isword) begin
            a_ext = {{HALF{mul.i_mul_srcA[HALF-1]}}, mul.i_mul_srcA[HALF-1:0]};
            b_ext = {{HALF{mul.i_mul_srcB[HALF-1]}}, mul.i_mul_srcB[HALF-1:0]};
        end
        sa = mul_a_signed(op_in, mul.i_mul_isword) && a_ext[XLEN-1];
        sb = mul_b_signed(op_in, mul.i_mul_isword) && b_ext[XLEN-1];
        // -INT_MIN wraps to 2^(XLEN-1), which is the correct unsigned magnitude.
        s1_d.mag_a       = sa ? -a_ext : a_ext;
        s1_d.mag_b       = sb ? -b_ext : b_ext;
        s1_d.ctrl.op     = op_in;
        s1_d.ctrl.isword = mul.i_mul_isword;
        s1_d.ctrl.neg    = sa ^ sb;
        s1_d.tag         = mul.i_mul_tag;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (mul.i_mul_flush) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) s1_q <= s1_d;
        end
    end

    // ---------------- stages 2..STAGES-1: product ----------------
    logic              fin_in_valid;
    logic [2*XLEN-1:0] fin_in_prod;
    mul_ctrl_t         fin_in_ctrl;
    logic [TAG_W-1:0]  fin_in_tag;

    if (PDEPTH == 0) begin : g_comb_mul
        assign fin_in_valid = s1_valid;
        assign fin_in_prod  = {{XLEN{1'b0}}, s1_q.mag_a} * {{XLEN{1'b0}}, s1_q.mag_b};
        assign fin_in_ctrl  = s1_q.ctrl;
        assign fin_in_tag   = s1_q.tag;
    end else begin : g_prod_pipe
        logic [PDEPTH-1:0] pv;
        logic [2*XLEN-1:0] pp [PDEPTH];
        mul_ctrl_t         pc [PDEPTH];
        logic [TAG_W-1:0]  pt [PDEPTH];

        // Product formed on entry; later stages only carry it, leaving
        // synthesis free to retime the multiplier across them.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                pv <= '0;
                for (int unsigned i = 0; i < PDEPTH; i++) begin
                    pp[i] <= '0;
                    pc[i] <= '0;
                    pt[i] <= '0;
                end
            end else if (mul.i_mul_flush) begin
                pv <= '0;
            end else if (adv) begin
                pv[0] <= s1_valid;
                if (s1_valid) begin
                    pp[0] <= {{XLEN{1'b0}}, s1_q.mag_a} * {{XLEN{1'b0}}, s1_q.mag_b};
                    pc[0] <= s1_q.ctrl;
                    pt[0] <= s1_q.tag;
                end
                for (int unsigned i = 1; i < PDEPTH; i++) begin
                    pv[i] <= pv[i-1];
                    if (pv[i-1]) begin
                        pp[i] <= pp[i-1];
                        pc[i] <= pc[i-1];
                        pt[i] <= pt[i-1];
                    end
                end
            end
        end

        assign fin_in_valid = pv[PDEPTH-1];
        assign fin_in_prod  = pp[PDEPTH-1];
        assign fin_in_ctrl  = pc[PDEPTH-1];
        assign fin_in_tag   = pt[PDEPTH-1];
    end

    // ---------------- final stage: sign fix and select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fin_d;
    logic              fin_valid;
    logic [XLEN-1:0]   fin_result;
    logic [TAG_W-1:0]  fin_tag;

    always_comb begin
        prod_fix = fin_in_ctrl.neg ? -fin_in_prod : fin_in_prod;
        if (fin_in_ctrl.isword)
            fin_d = {{HALF{prod_fix[HALF-1]}}, prod_fix[HALF-1:0]};
        else if (fin_in_ctrl.op == MUL_OP_MUL)
            fin_d = prod_fix[XLEN-1:0];
        else
            fin_d = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fin_valid  <= 1'b0;
            fin_result <= '0;
            fin_tag    <= '0;
        end else if (mul.i_mul_flush) begin
            fin_valid <= 1'b0;
        end else if (adv) begin
            fin_valid <= fin_in_valid;
            if (fin_in_valid) begin
                fin_result <= fin_d;
                fin_tag    <= fin_in_tag;
            end
        end
    end

    // ---------------- output ----------------
`ifdef RISCV_CORE_MUL_SKID_EN
    logic                    skid_up_ready;
    logic [XLEN+TAG_W-1:0]   skid_dn_data;

    riscv_core_mul_skid #(
        .W(XLEN + TAG_W)
    ) u_skid (
        .clk      (i_clk),
        .rst      (i_rst),
        .flush    (mul.i_mul_flush),
        .up_valid (fin_valid),
        .up_ready (skid_up_ready),
        .up_data  ({fin_tag, fin_result}),
        .dn_valid (mul.o_mul_valid),
        .dn_ready (mul.i_mul_ready),
        .dn_data  (skid_dn_data)
    );

    // Pipeline only holds while the skid entry is occupied.
    assign adv              = skid_up_ready;
    assign mul.o_mul_result = skid_dn_data[XLEN-1:0];
    assign mul.o_mul_tag    = skid_dn_data[XLEN+TAG_W-1:XLEN];
`else
    assign adv              = !(fin_valid && !mul.i_mul_ready);
    assign mul.o_mul_valid  = fin_valid;
    assign mul.o_mul_result = fin_result;
    assign mul.o_mul_tag    = fin_tag;
`endif

    assign mul.o_mul_ready = adv;

endmodule

// File: tb/tb_riscv_core_mul_unit.sv
module tb_riscv_core_mul_unit;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STAGES = 3;
    localparam int unsigned TAG_W  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_core_mul_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) mif ();

    riscv_core_mul_unit #(
        .XLEN   (XLEN),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .mul   (mif)
    );

    int n_checks;
    int n_errors;
    int n_retired;
    bit mon_en;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  ctl;
        logic        w;
        logic [4:0]  tag;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain signed arithmetic on widened operands.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] ctl, input logic w);
        logic signed [127:0] xa, xb, p;
        if (w) begin
            xa = {{96{a[31]}}, a[31:0]};
            xb = {{96{b[31]}}, b[31:0]};
            p  = xa * xb;
            return {{32{p[31]}}, p[31:0]};
        end
        xa = (ctl != 2'b11) ? {{64{a[63]}}, a} : {64'b0, a};
        xb = (ctl <= 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = xa * xb;
        return (ctl == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(7))
            0:       return 64'h0;
            1:       return 64'h1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'h7FFF_FFFF_FFFF_FFFF;
            5:       return {$urandom(), 32'h8000_0000};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                         input logic w, input logic [4:0] t);
        mif.i_mul_valid   = 1'b1;
        mif.i_mul_srcA    = a;
        mif.i_mul_srcB    = b;
        mif.i_mul_control = c;
        mif.i_mul_isword  = w;
        mif.i_mul_tag     = t;
    endtask

    task automatic drive_rand();
        drive(rand64(), rand64(), 2'($urandom_range(3)), ($urandom_range(3) == 0),
              5'($urandom_range(31)));
    endtask

    // Called at posedge+1 with an empty pipe; checks latency, result, tag.
    task automatic run_vec(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                           input logic w, input logic [4:0] t, input logic [63:0] exp);
        int cyc;
        mif.i_mul_ready = 1'b1;
        drive(a, b, c, w, t);
        @(posedge clk); #1;
        mif.i_mul_valid = 1'b0;
        cyc = 1;
        while (!mif.o_mul_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(STAGES));
        chk("vec_result", mif.o_mul_result, exp);
        chk("vec_tag", 64'(mif.o_mul_tag), 64'(t));
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: orders results, handshake rule, stall stability.
    logic        stall_prev = 1'b0;
    logic [63:0] prev_res;
    logic [4:0]  prev_tag;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sb_q.delete();
                stall_prev = 1'b0;
            end else begin
                chk("ready_rule", 64'(mif.o_mul_ready),
                    64'(!(mif.o_mul_valid && !mif.i_mul_ready)));
                if (stall_prev) begin
                    chk("stall_valid", 64'(mif.o_mul_valid), 64'd1);
                    chk("stall_result", mif.o_mul_result, prev_res);
                    chk("stall_tag", 64'(mif.o_mul_tag), 64'(prev_tag));
                end
                if (mif.o_mul_valid) begin
                    chk("spurious_valid", 64'(sb_q.size() != 0), 64'd1);
                    if (mif.i_mul_ready && sb_q.size() != 0) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("sb_result", mif.o_mul_result, e.res);
                        chk("sb_tag", 64'(mif.o_mul_tag), 64'(e.tag));
                        n_retired++;
                    end
                end
                if (mif.i_mul_flush) begin
                    sb_q.delete();
                end else if (mif.i_mul_valid && mif.o_mul_ready) begin
                    exp_t e;
                    e.res = ref_mul(mif.i_mul_srcA, mif.i_mul_srcB, mif.i_mul_control,
                                    mif.i_mul_isword);
                    e.tag = mif.i_mul_tag;
                    sb_q.push_back(e);
                end
                stall_prev = mif.o_mul_valid && !mif.i_mul_ready && !mif.i_mul_flush;
                prev_res   = mif.o_mul_result;
                prev_tag   = mif.o_mul_tag;
            end
        end
    end

    initial begin
        int idx;
        int base;
        int quiet;
        bit acc;

        n_checks  = 0;
        n_errors  = 0;
        n_retired = 0;
        mon_en    = 1'b0;

        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b00, 1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[1]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 5'd1, 64'h4000_0000_0000_0000};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4]  = '{64'h1234_5678_7FFF_FFFF, 64'd2, 2'b00, 1'b1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 5'd5, 64'h8000_0000_0000_0000};
        vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 5'd6, 64'h0};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'b11, 1'b1, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'd2, 2'b10, 1'b0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{64'h8000_0000_0000_0000, 64'd2, 2'b11, 1'b0, 5'd10, 64'h1};
        vecs[10] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 2'b01, 1'b1, 5'd11, 64'h0};
        vecs[11] = '{64'h0, 64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0, 5'd31, 64'h0};

        rst               = 1'b1;
        mif.i_mul_valid   = 1'b0;
        mif.i_mul_srcA    = '0;
        mif.i_mul_srcB    = '0;
        mif.i_mul_control = 2'b00;
        mif.i_mul_isword  = 1'b0;
        mif.i_mul_tag     = '0;
        mif.i_mul_flush   = 1'b0;
        mif.i_mul_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("reset_valid", 64'(mif.o_mul_valid), 64'd0);
        chk("reset_result", mif.o_mul_result, 64'd0);
        chk("reset_tag", 64'(mif.o_mul_tag), 64'd0);
        chk("reset_ready", 64'(mif.o_mul_ready), 64'd1);

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].w, vecs[i].tag, vecs[i].exp);

        // 8 back-to-back ops, consumer stalls for 3 cycles mid-stream.
        base = n_retired;
        idx  = 0;
        for (int c = 0; c < 30; c++) begin
            mif.i_mul_ready = !(c >= 3 && c < 6);
            if (idx < 8) drive_rand();
            else mif.i_mul_valid = 1'b0;
            #2;
            if (!mif.i_mul_ready && mif.o_mul_valid)
                chk("stall_ready_low", 64'(mif.o_mul_ready), 64'd0);
            acc = mif.i_mul_valid && mif.o_mul_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        mif.i_mul_valid = 1'b0;
        mif.i_mul_ready = 1'b1;
        chk("stream_accepted", 64'(idx), 64'd8);
        chk("stream_retired", 64'(n_retired - base), 64'd8);

        // Flush with two ops in flight and a third offered in the flush cycle.
        drive(64'd11, 64'd13, 2'b00, 1'b0, 5'd20);
        @(posedge clk); #1;
        drive(64'd17, 64'd19, 2'b00, 1'b0, 5'd21);
        @(posedge clk); #1;
        drive(64'd23, 64'd29, 2'b00, 1'b0, 5'd22);
        mif.i_mul_flush = 1'b1;
        @(posedge clk); #1;
        mif.i_mul_flush = 1'b0;
        chk("flush_valid", 64'(mif.o_mul_valid), 64'd0);
        run_vec(64'd6, 64'd7, 2'b00, 1'b0, 5'd23, 64'd42);
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            if (mif.o_mul_valid) quiet++;
            @(posedge clk); #1;
        end
        chk("flush_no_ghost", 64'(quiet), 64'd0);

        // Same again with reset instead of flush.
        drive(64'd11, 64'd13, 2'b00, 1'b0, 5'd24);
        @(posedge clk); #1;
        drive(64'd17, 64'd19, 2'b01, 1'b0, 5'd25);
        @(posedge clk); #1;
        drive(64'd23, 64'd29, 2'b00, 1'b0, 5'd26);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mif.i_mul_valid = 1'b0;
        chk("rst_valid", 64'(mif.o_mul_valid), 64'd0);
        chk("rst_result", mif.o_mul_result, 64'd0);
        chk("rst_tag", 64'(mif.o_mul_tag), 64'd0);
        chk("rst_ready", 64'(mif.o_mul_ready), 64'd1);
        quiet = 0;
        for (int c = 0; c < 5; c++) begin
            if (mif.o_mul_valid) quiet++;
            @(posedge clk); #1;
        end
        chk("rst_no_ghost", 64'(quiet), 64'd0);
        run_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 2'b00, 1'b0, 5'd27, 64'hFFFF_FFFF_FFFF_FFF7);

        // Randomised traffic: random offers, back-pressure and occasional flush.
        for (int c = 0; c < 400; c++) begin
            mif.i_mul_ready = ($urandom_range(3) != 0);
            mif.i_mul_flush = !mif.o_mul_valid && ($urandom_range(49) == 0);
            if ($urandom_range(3) != 0) drive_rand();
            else mif.i_mul_valid = 1'b0;
            @(posedge clk); #1;
        end
        mif.i_mul_valid = 1'b0;
        mif.i_mul_flush = 1'b0;
        mif.i_mul_ready = 1'b1;
        for (int c = 0; c < 50 && sb_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
